// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId, exception and interrupt request generation for the M stage.
// Req is raised combinationally and all CP0 state updates land on the following rising edge.
module cp0 (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [4:0]  CP0_addr,
   input  logic [31:0] CP0_in,
   output logic [31:0] CP0_out,
   input  logic [31:0] VPC,
   input  logic        BD_in,
   input  logic [4:0]  ExcCode_in,
   input  logic [5:0]  HWInt,
   input  logic        EXL_clr,
   output logic [31:0] EPC_out,
   output logic        Req
);

   localparam logic [4:0]  AddrSr    = 5'd12;
   localparam logic [4:0]  AddrCause = 5'd13;
   localparam logic [4:0]  AddrEpc   = 5'd14;
   localparam logic [4:0]  AddrPrid  = 5'd15;
   localparam logic [31:0] PridValue = 32'h0000_2025;

   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic [31:0] epc_q, epc_d;

   logic        int_req;
   logic        exc_req;
   logic [31:0] sr_val;
   logic [31:0] cause_val;

   always_comb begin
      int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
      exc_req = (ExcCode_in != 5'd0) & ~exl_q;
      Req     = (int_req | exc_req) & ~reset;
   end

   always_comb begin
      sr_val    = {16'b0, im_q, 8'b0, exl_q, ie_q};
      cause_val = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
      EPC_out   = epc_q;
      unique case (CP0_addr)
         AddrSr:    CP0_out = sr_val;
         AddrCause: CP0_out = cause_val;
         AddrEpc:   CP0_out = epc_q;
         AddrPrid:  CP0_out = PridValue;
         default:   CP0_out = 32'd0;
      endcase
   end

   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ip_d       = ip_q;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      if (reset) begin
         im_d       = 6'd0;
         exl_d      = 1'b0;
         ie_d       = 1'b0;
         bd_d       = 1'b0;
         ip_d       = 6'd0;
         exc_code_d = 5'd0;
         epc_d      = 32'd0;
      end else begin
         ip_d = HWInt;
         if (Req) begin
            exl_d      = 1'b1;
            bd_d       = BD_in;
            exc_code_d = int_req ? 5'd0 : ExcCode_in;
            epc_d      = BD_in ? (VPC - 32'd4) : VPC;
         end else begin
            if (en) begin
               if (CP0_addr == AddrSr) begin
                  im_d  = CP0_in[15:10];
                  exl_d = CP0_in[1];
                  ie_d  = CP0_in[0];
               end else if (CP0_addr == AddrEpc) begin
                  epc_d = CP0_in;
               end
            end
            // eret wins over a same-edge mtc0 to SR
            if (EXL_clr) begin
               exl_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
   end

endmodule
